regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 103 ++++++++++
 tb/tb_regfile_mp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_RD combinational read ports and a sequential bulk-clear sweep.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
`default_nettype none

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     wr_err
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_wr_err;
  logic              w_idle;
  logic              w_wa_zero;
  logic              w_wr_ok;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_wa_zero = (ZERO_REG != 0) && (wa == '0);
  assign w_wr_ok   = we && w_idle && !w_wa_zero;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (clr_req)      w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (r_cnt == '1)  w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // The counter saturates on the last sweep edge; IDLE reloads it to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_err <= we && !w_idle;
      if (w_idle)
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (!w_idle) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wa] <= wd;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rdata;

    assign w_ra = ra[i*ADDR_W +: ADDR_W];

    always_comb begin
      w_rdata = r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_ok && (w_ra == wa))
        w_rdata = wd;
`endif
      if ((ZERO_REG != 0) && (w_ra == '0))
        w_rdata = '0;
    end

    assign rd[i*DATA_W +: DATA_W] = w_rdata;
  end

  assign busy   = !w_idle;
  assign wr_err = r_wr_err;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: vector table, directed sweep/reset sequences and random traffic against an array-based model.
`default_nettype none

module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             we = 1'b0;
  logic             clr_req = 1'b0;
  logic [AW-1:0]    wa = '0;
  logic [DW-1:0]    wd = '0;
  logic [NR*AW-1:0] ra = '0;
  logic [NR*DW-1:0] rd;
  logic             busy;
  logic             wr_err;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .clr_req(clr_req), .busy(busy), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] m [DEPTH];
  int            sweep_left;
  int            sweep_idx;
  logic          m_err;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [AW-1:0] r0;
    logic [AW-1:0] r1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && sweep_left == 0 && wa == a) return wd;
`endif
    return m[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    sweep_left = 0;
    sweep_idx  = 0;
    m_err      = 1'b0;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic c);
    we = w; wa = a; wd = d; ra = {r1, r0}; clr_req = c;
    #2;
  endtask

  task automatic chk_rd();
    chk("rd0", rd[DW-1:0], exp_rd(ra[AW-1:0]));
    chk("rd1", rd[2*DW-1:DW], exp_rd(ra[2*AW-1:AW]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (sweep_left > 0) begin
      m[sweep_idx] = '0;
      sweep_idx++;
      sweep_left--;
      m_err = we;
    end else begin
      if (we && wa != 0) m[wa] = wd;
      m_err = 1'b0;
      if (clr_req) begin
        sweep_left = DEPTH;
        sweep_idx  = 0;
      end
    end
    #1;
    chk("busy", {31'b0, busy}, {31'b0, (sweep_left > 0)});
    chk("wr_err", {31'b0, wr_err}, {31'b0, m_err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int e;
    tbl[0] = '{1'b1, 5'd7,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h12345678, 32'h12345678};
    tbl[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd7,  5'd0,  32'h12345678, 32'h0};
    tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h12345678};
    tbl[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd30, 5'd1,  32'h0,        32'h0};
    tbl[5] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  32'hCAFEF00D, 32'h12345678};
    tbl[6] = '{1'b1, 5'd1,  32'h00000001, 5'd31, 5'd0,  32'hCAFEF00D, 32'h0};
    tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd1,  32'h00000001, 32'h00000001};

    model_reset();
    #12 rst_n = 1'b1;
    tick();
    drive(1'b0, '0, '0, 5'd5, 5'd31, 1'b0);
    chk_rd();

    // asynchronous reset mid-cycle
    tick();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 5'd5, 5'd5, 1'b0);
    chk("pre_rst_r5", rd[DW-1:0], 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_r5", rd[DW-1:0], 32'h0);
    chk("async_rst_busy", {31'b0, busy}, 32'h0);
    chk("async_rst_err", {31'b0, wr_err}, 32'h0);
    #2 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].r0, tbl[i].r1, 1'b0);
      chk("tbl_rd0", rd[DW-1:0], tbl[i].e0);
      chk("tbl_rd1", rd[2*DW-1:DW], tbl[i].e1);
      tick();
    end

    drive(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd7, 1'b0);
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", rd[DW-1:0], 32'hA5A5A5A5);
`else
    chk("byp_same", rd[DW-1:0], 32'h0);
`endif
    chk("byp_other", rd[2*DW-1:DW], 32'h12345678);
    tick();
    drive(1'b0, '0, '0, 5'd9, 5'd9, 1'b0);
    chk("byp_next", rd[DW-1:0], 32'hA5A5A5A5);
    tick();

    // full sweep with dropped writes in the middle
    for (int a = 1; a < DEPTH; a++) begin
      drive(1'b1, AW'(a), DW'(a), 5'd0, 5'd0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 5'd0, 5'd0, 1'b1);
    tick();
    b = busy ? 1 : 0;
    e = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 12 || k == 13) drive(1'b1, 5'd4, 32'h55, 5'd3, 5'd20, 1'b0);
      else                    drive(1'b0, '0, '0, 5'd3, 5'd20, 1'b0);
      if (k == 10) begin
        chk("mid_r3", rd[DW-1:0], 32'h0);
        chk("mid_r20", rd[2*DW-1:DW], 32'd20);
      end
      chk_rd();
      tick();
      if (busy) b++;
      if (wr_err) e++;
      if (!busy) break;
    end
    chk("busy_len", DW'(b), 32'd32);
    chk("wr_err_len", DW'(e), 32'd2);
    for (int a = 0; a < DEPTH; a += 2) begin
      drive(1'b0, '0, '0, AW'(a), AW'(a + 1), 1'b0);
      chk("post_clr0", rd[DW-1:0], 32'h0);
      chk("post_clr1", rd[2*DW-1:DW], 32'h0);
      tick();
    end

    // reset during a sweep
    drive(1'b1, 5'd25, 32'h2525, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 5'd0, 5'd0, 1'b1);
    tick();
    for (int k = 0; k < 15; k++) begin
      drive(1'b0, '0, '0, 5'd25, 5'd0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 5'd25, 5'd0, 1'b0);
    chk("sweep15_r25", rd[DW-1:0], 32'h2525);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_r25", rd[DW-1:0], 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a += 2) begin
      drive(1'b0, '0, '0, AW'(a), AW'(a + 1), 1'b0);
      chk("rst_clr0", rd[DW-1:0], 32'h0);
      chk("rst_clr1", rd[2*DW-1:DW], 32'h0);
      tick();
    end
    drive(1'b1, 5'd2, 32'h77, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 5'd2, 5'd2, 1'b0);
    chk("post_rst_wr", rd[DW-1:0], 32'h77);
    tick();

    // clr_req held high: back-to-back sweeps
    for (int k = 0; k < 70; k++) begin
      drive(k[0], AW'($urandom), $urandom, AW'(k), AW'($urandom), 1'b1);
      chk_rd();
      tick();
    end

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom), $urandom, AW'($urandom), AW'($urandom),
            ($urandom_range(0, 39) == 0));
      chk_rd();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
